counter_mod_n: RTL and testbench
================================

COUNTER_MOD_N -- requirements
Module: counter_mod_n

Interface
REQ-001 Parameter W, default 4: counter width in bits, 2..8.
REQ-002 Parameter MOD, default 10: count modulus, 2..2^W; legal count values 0..MOD-1.
REQ-003 Reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 enablen  input  1  count enable, active-low.
REQ-007 load  input  1  parallel load strobe, active-high.
REQ-008 up  input  1  direction: 1 = count up, 0 = count down.
REQ-009 in  input  W  parallel load value.
REQ-010 upper_zero  input  1  cascade status from the next-higher stage: 1 = all higher stages at 0.
REQ-011 count  output  W  current count, registered.
REQ-012 rco_L  output  1  ripple carry/borrow out, active-low, combinational from state and inputs.
REQ-013 done  output  1  terminal flag, combinational; meaningful only with the macro in REQ-030.

Function
REQ-014 Per-edge priority: rst > load > count enable > hold.
REQ-015 load=1: count <= in if in < MOD; count <= MOD-1 if in >= MOD (clamp); up and enablen are ignored that cycle.
REQ-016 load=0, enablen=0, up=1: count <= count+1; at MOD-1, wrap to 0.
REQ-017 load=0, enablen=0, up=0: count <= count-1; at 0, wrap to MOD-1, except as in REQ-031.
REQ-018 enablen=1, load=0: count holds.
REQ-019 Latency: count reflects load or step one edge after the qualifying inputs are sampled; no multi-cycle paths.
REQ-020 rco_L=0 iff enablen=0 and count is at terminal (MOD-1 if up=1, 0 if up=0) and the stage is not held per REQ-031; otherwise rco_L=1.
REQ-021 rco_L is independent of load, so the higher stage may be loaded in the same cycle.
REQ-022 A change of up takes effect on the next enabled edge; it causes no extra step, and terminal detection follows the new direction combinationally.
REQ-023 count never leaves 0..MOD-1 under any input sequence, including MOD not a power of two.
REQ-024 Cascading N stages: stage k enablen is driven by stage k-1 rco_L. Stage k upper_zero is the AND of done-or-zero status of stages above k; the top stage ties upper_zero=1.

Reset
REQ-025 rst=1 at a rising edge: count <= 0, regardless of load, enablen, up.
REQ-026 Combinational outputs after reset follow REQ-020 and REQ-032 with count=0.
REQ-027 rst asserted mid-count or simultaneously with load: reset wins; the load is discarded.
REQ-028 Before the first reset, outputs are undefined; the bench applies rst for at least one edge.
REQ-029 There is no asynchronous path from rst to any output.

Configuration
REQ-030 Macro COUNTER_CASCADE_HOLD_EN selects cascade hold-at-zero.
REQ-031 Defined: with up=0, count=0 and upper_zero=1, an enabled edge holds count at 0 (no wrap), and rco_L stays 1.
REQ-032 Defined: done=1 iff up=0 and count=0 and upper_zero=1; otherwise done=0.
REQ-033 Not defined: upper_zero is ignored, down count always wraps 0 -> MOD-1, and done is tied to 0.

Verification
REQ-034 MOD=10, W=4, rst=1 one edge, then up=0, enablen=0, macro off: 0,9,8,...,1,0,9; rco_L=0 exactly in cycles where count=0.
REQ-035 MOD=6, up=1, enablen=0: 0..5,0; rco_L=0 only at count=5; enablen=1 at count=3 holds 3 for 4 cycles, with rco_L=1.
REQ-036 MOD=10, load=1, in=12 -> count=9; load=1 with enablen=0 and in=4 -> count=4 (load wins); rst=1 with load=1, in=7 -> count=0.
REQ-037 Macro on, MOD=10, up=0, upper_zero=1, count loaded 2: 2,1,0,0,0; done=1 from count=0; rco_L=1 throughout. Drop upper_zero to 0: next edge count=9, with rco_L=0 in the cycle before.
REQ-038 Two stages, MOD=10, cascaded per REQ-024, macro on, both loaded 0 then high stage 2, low stage 3, down count: 23,22,...,20,19,...,00, then hold at 00 with top done=1.
REQ-039 up toggled 0 -> 1 at count=0 with MOD=10: rco_L goes 1 in the same cycle, and the next edge gives count=1.

Source files
------------

// File: rtl/counter_mod_n.sv
// counter_mod_n: cascadable modulo-MOD up/down counter with parallel load.
//
// Build option:
//   COUNTER_CASCADE_HOLD_EN  when defined, a down-counting stage sitting at 0
//                            with all higher stages at 0 (upper_zero=1) holds
//                            at 0 instead of wrapping, and raises done.
//                            When undefined, upper_zero has no effect, the
//                            counter always wraps 0 -> MOD-1 and done is 0.
//
// Per-edge priority: rst > load > count enable (enablen low) > hold.
// rco_L depends only on state, enablen, up and the cascade hold condition,
// never on load, so a higher stage can be loaded in the same cycle.

module counter_mod_n #(
   parameter int W   = 4,
   parameter int MOD = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enablen,
   input  logic         load,
   input  logic         up,
   input  logic [W-1:0] in,
   input  logic         upper_zero,
   output logic [W-1:0] count,
   output logic         rco_L,
   output logic         done
);

   localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);
   localparam logic [W-1:0] ONE     = W'(1);
   localparam logic [W:0]   MOD_EXT = (W + 1)'(MOD);

`ifdef COUNTER_CASCADE_HOLD_EN
   localparam logic HOLD_EN = 1'b1;
`else
   localparam logic HOLD_EN = 1'b0;
`endif

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic [W-1:0] load_val;
   logic [W-1:0] inc_val;
   logic [W-1:0] dec_val;
   logic         at_top;
   logic         at_zero;
   logic         terminal;
   logic         hold_zero;
   logic         step_en;

   // Terminal and cascade-hold detection from current state and live inputs.
   always_comb begin
      at_top    = (count_q == MAX_VAL);
      at_zero   = (count_q == '0);
      terminal  = up ? at_top : at_zero;
      hold_zero = HOLD_EN & ~up & at_zero & upper_zero;
      step_en   = ~enablen;
   end

   // Combinational status outputs; a held stage never ripples a borrow.
   always_comb begin
      rco_L = ~(step_en & terminal & ~hold_zero);
      done  = hold_zero;
   end

   // Candidate next values; out-of-range state is folded back into range.
   always_comb begin
      load_val = ({1'b0, in} >= MOD_EXT) ? MAX_VAL : in;

      if (count_q >= MAX_VAL) begin
         inc_val = '0;
      end else begin
         inc_val = count_q + ONE;
      end

      if (count_q > MAX_VAL) begin
         dec_val = MAX_VAL;
      end else if (at_zero) begin
         dec_val = hold_zero ? '0 : MAX_VAL;
      end else begin
         dec_val = count_q - ONE;
      end
   end

   // Next-state select: load beats counting, otherwise hold.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (step_en) begin
         count_d = up ? inc_val : dec_val;
      end
   end

   // State register with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed bench for counter_mod_n: vector table on a MOD=10 stage, plus
// hand sequences for MOD=6 hold, direction toggle and a two-stage cascade.

module tb_counter_mod_n;

`ifdef COUNTER_CASCADE_HOLD_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // decade stage driven from the vector table
   logic       rst, load, en_n, up, uz;
   logic [3:0] din;
   logic [3:0] cnt;
   logic       rco, dn;

   counter_mod_n #(.W(4), .MOD(10)) u_dut (
      .clk(clk), .rst(rst), .enablen(en_n), .load(load), .up(up), .in(din),
      .upper_zero(uz), .count(cnt), .rco_L(rco), .done(dn));

   // modulo-6 stage
   logic       rst6, load6, en6_n, up6;
   logic [3:0] din6;
   logic [3:0] cnt6;
   logic       rco6, dn6;

   counter_mod_n #(.W(4), .MOD(6)) u_m6 (
      .clk(clk), .rst(rst6), .enablen(en6_n), .load(load6), .up(up6), .in(din6),
      .upper_zero(1'b1), .count(cnt6), .rco_L(rco6), .done(dn6));

   // Two-stage cascade
   logic       rst_c, lo_load, hi_load, lo_en_n, up_c;
   logic [3:0] lo_in, hi_in, lo_cnt, hi_cnt;
   logic       lo_rco, hi_rco, lo_done, hi_done, lo_uz;

   assign lo_uz = (hi_cnt == 4'd0) | hi_done;

   counter_mod_n #(.W(4), .MOD(10)) u_lo (
      .clk(clk), .rst(rst_c), .enablen(lo_en_n), .load(lo_load), .up(up_c), .in(lo_in),
      .upper_zero(lo_uz), .count(lo_cnt), .rco_L(lo_rco), .done(lo_done));

   counter_mod_n #(.W(4), .MOD(10)) u_hi (
      .clk(clk), .rst(rst_c), .enablen(lo_rco), .load(hi_load), .up(up_c), .in(hi_in),
      .upper_zero(1'b1), .count(hi_cnt), .rco_L(hi_rco), .done(hi_done));

   typedef struct {
      logic       rst;
      logic       load;
      logic       en_n;
      logic       up;
      logic       uz;
      logic [3:0] din;
      logic       cc;       // check combinational outputs before the edge
      logic       exp_rco;
      logic       exp_done;
      logic [3:0] exp_cnt;  // count after the edge
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic l, input logic e, input logic u,
                      input logic z, input logic [3:0] d, input logic c,
                      input logic er, input logic ed, input logic [3:0] ec);
      vec_t v;
      v.rst = r; v.load = l; v.en_n = e; v.up = u; v.uz = z; v.din = d;
      v.cc = c; v.exp_rco = er; v.exp_done = ed; v.exp_cnt = ec;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int e;
      int exp_v;

      rst6 = 1'b0; load6 = 1'b0; en6_n = 1'b1; up6 = 1'b1; din6 = '0;
      rst_c = 1'b0; lo_load = 1'b0; hi_load = 1'b0; lo_en_n = 1'b1; up_c = 1'b0;
      lo_in = '0; hi_in = '0;

      // reset together with a load: reset wins
      add(1, 1, 0, 1, 0, 4'd7, 0, 1, 0, 4'd0);
      // down count with wrap: borrow only while at 0
      for (int k = 0; k <= 10; k++) begin
         p = (k == 0 || k == 10) ? 0 : 10 - k;
         e = (p == 0) ? 9 : p - 1;
         add(0, 0, 0, 0, 0, 4'd0, 1, (p != 0), 0, 4'(e));
      end
      // loads: beat enable, clamp at MOD-1, rco_L ignores load
      add(0, 1, 0, 1, 0, 4'd4,  1, 0, 0, 4'd4);
      add(0, 1, 1, 1, 0, 4'd12, 1, 1, 0, 4'd9);
      add(0, 1, 1, 1, 0, 4'd0,  1, 1, 0, 4'd0);
      add(0, 1, 0, 0, 0, 4'd10, 1, 0, 0, 4'd9);
      add(0, 0, 1, 1, 0, 4'd0,  1, 1, 0, 4'd9);
      add(0, 0, 0, 1, 0, 4'd0,  1, 0, 0, 4'd0);
      add(0, 0, 0, 1, 0, 4'd0,  1, 1, 0, 4'd1);
      add(0, 0, 0, 1, 0, 4'd0,  1, 1, 0, 4'd2);
      // reset mid-count
      add(1, 0, 0, 1, 0, 4'd0,  1, 1, 0, 4'd0);
      // cascade hold at zero with upper_zero
      add(0, 1, 1, 0, 1, 4'd2,  1, 1, HOLD_EN, 4'd2);
      add(0, 0, 0, 0, 1, 4'd0,  1, 1, 0, 4'd1);
      add(0, 0, 0, 0, 1, 4'd0,  1, 1, 0, 4'd0);
      if (HOLD_EN) begin
         add(0, 0, 0, 0, 1, 4'd0, 1, 1, 1, 4'd0);
         add(0, 0, 0, 0, 1, 4'd0, 1, 1, 1, 4'd0);
         add(0, 0, 0, 0, 0, 4'd0, 1, 0, 0, 4'd9);
      end else begin
         add(0, 0, 0, 0, 1, 4'd0, 1, 0, 0, 4'd9);
         add(0, 0, 0, 0, 1, 4'd0, 1, 1, 0, 4'd8);
         add(0, 0, 0, 0, 0, 4'd0, 1, 1, 0, 4'd7);
      end
      add(0, 1, 1, 1, 0, 4'd15, 1, 1, 0, 4'd9);
      add(0, 0, 0, 1, 0, 4'd0,  1, 0, 0, 4'd0);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; load = vecs[i].load; en_n = vecs[i].en_n;
         up = vecs[i].up; uz = vecs[i].uz; din = vecs[i].din;
         #1;
         if (vecs[i].cc) begin
            chk($sformatf("vec%0d rco_L", i), int'(rco), int'(vecs[i].exp_rco));
            chk($sformatf("vec%0d done", i), int'(dn), int'(vecs[i].exp_done));
         end
         edge_settle();
         chk($sformatf("vec%0d count", i), int'(cnt), int'(vecs[i].exp_cnt));
      end

      // direction toggle at 0: terminal detection follows up immediately
      rst = 1'b0; load = 1'b0; en_n = 1'b0; up = 1'b0; uz = 1'b0; din = '0;
      #1;
      chk("toggle rco_L down", int'(rco), 0);
      up = 1'b1;
      #1;
      chk("toggle rco_L up", int'(rco), 1);
      edge_settle();
      chk("toggle count", int'(cnt), 1);

      // modulo-6 up count with wrap, then hold
      rst6 = 1'b1;
      edge_settle();
      rst6 = 1'b0;
      chk("m6 reset count", int'(cnt6), 0);
      en6_n = 1'b0;
      for (int k = 0; k < 9; k++) begin
         #1;
         chk($sformatf("m6 rco_L k%0d", k), int'(rco6), ((k % 6) == 5) ? 0 : 1);
         edge_settle();
         chk($sformatf("m6 count k%0d", k), int'(cnt6), (k + 1) % 6);
      end
      en6_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("m6 hold rco_L k%0d", k), int'(rco6), 1);
         edge_settle();
         chk($sformatf("m6 hold count k%0d", k), int'(cnt6), 3);
      end

      // two-stage cascade: load 00, then 23, count down
      rst_c = 1'b1;
      edge_settle();
      rst_c = 1'b0;
      chk("casc reset", int'(hi_cnt) * 10 + int'(lo_cnt), 0);
      lo_load = 1'b1; hi_load = 1'b1; lo_in = 4'd0; hi_in = 4'd0;
      edge_settle();
      lo_in = 4'd3; hi_in = 4'd2;
      edge_settle();
      chk("casc load", int'(hi_cnt) * 10 + int'(lo_cnt), 23);
      lo_load = 1'b0; hi_load = 1'b0; lo_en_n = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         edge_settle();
         if (HOLD_EN) exp_v = (23 - k > 0) ? 23 - k : 0;
         else         exp_v = (123 - k) % 100;
         chk($sformatf("casc step %0d", k), int'(hi_cnt) * 10 + int'(lo_cnt), exp_v);
      end
      chk("casc top done", int'(hi_done), int'(HOLD_EN));
      chk("casc low rco_L", int'(lo_rco), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
